// File: rtl/jelly2_img_pkg.sv
// Shared types and helpers for the image-bus to AXI4-Stream converter.
package jelly2_img_pkg;

  // Frame synchronisation: pixels are only accepted once a frame start has been seen.
  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } img_sync_state_t;

  // One FIFO entry holds {tuser, col_last, data}; tuser already carries SOF in bit 0.
  function automatic int img_entry_width(input int tuser_width, input int tdata_width);
    return tuser_width + 1 + tdata_width;
  endfunction

endpackage

// File: rtl/jelly2_img_to_axi4s_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// The head entry is read straight from the storage array addressed by the
// registered read pointer, so valid/data change only on clock edges.
module jelly2_img_to_axi4s_fifo #(
  parameter int WIDTH     = 10,
  parameter int PTR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic [PTR_WIDTH:0]   level
);

  localparam int DEPTH = 2 ** PTR_WIDTH;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic               rd_ok;
  logic               wr_ok;

  assign rd_valid = (wr_ptr_q != rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                    (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign rd_data  = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign rd_ok = rd_en & rd_valid;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_WIDTH{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{PTR_WIDTH{1'b0}}, rd_ok};
  end

  // Pointer registers; reset flushes all contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/jelly2_img_to_axi4s_buffered.sv
// Converts the cke-gated image bus into AXI4-Stream video (SOF on tuser[0],
// EOL on tlast) through a FWFT FIFO, and requests upstream clock enable
// while enough free entries remain to absorb in-flight beats.
module jelly2_img_to_axi4s_buffered
  import jelly2_img_pkg::*;
#(
  parameter int TUSER_WIDTH    = 1,
  parameter int TDATA_WIDTH    = 8,
  parameter int FIFO_PTR_WIDTH = 5,
  parameter int CKE_MARGIN     = 4,
  localparam int USER_WIDTH    = (TUSER_WIDTH > 1) ? TUSER_WIDTH - 1 : 1
) (
  input  logic                      reset,
  input  logic                      clk,

  input  logic                      s_img_cke,
  input  logic                      s_img_row_first,
  input  logic                      s_img_row_last,
  input  logic                      s_img_col_first,
  input  logic                      s_img_col_last,
  input  logic                      s_img_de,
  input  logic [USER_WIDTH-1:0]     s_img_user,
  input  logic [TDATA_WIDTH-1:0]    s_img_data,
  input  logic                      s_img_valid,
  output logic                      m_img_cke_req,

  output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
  output logic                      m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]    m_axi4s_tdata,
  output logic                      m_axi4s_tvalid,
  input  logic                      m_axi4s_tready,

  input  logic                      clear_overflow,
  output logic                      status_overflow,
  output logic [FIFO_PTR_WIDTH:0]   status_level
);

  localparam int EW    = img_entry_width(TUSER_WIDTH, TDATA_WIDTH);
  localparam int DEPTH = 2 ** FIFO_PTR_WIDTH;
  localparam logic [FIFO_PTR_WIDTH:0] DEPTH_W  = (FIFO_PTR_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_PTR_WIDTH:0] MARGIN_W = (FIFO_PTR_WIDTH+1)'(CKE_MARGIN);

  img_sync_state_t state_q, state_d;
  logic            cke_req_q, cke_req_d;
  logic            overflow_q, overflow_d;

  logic                      beat;
  logic                      sof;
  logic                      push;
  logic                      pop;
  logic                      ovf_event;
  logic                      fifo_full;
  logic [FIFO_PTR_WIDTH:0]   level;
  logic [FIFO_PTR_WIDTH:0]   level_next;
  logic [FIFO_PTR_WIDTH:0]   free_next;
  logic [TUSER_WIDTH-1:0]    tuser_in;
  logic [EW-1:0]             wr_entry;
  logic [EW-1:0]             rd_entry;

  assign beat = s_img_cke & s_img_valid & s_img_de;
  assign sof  = beat & s_img_row_first & s_img_col_first;
  assign pop  = m_axi4s_tvalid & m_axi4s_tready;

  // Without user bits the sideband input and row_last are status only.
  generate
    if (TUSER_WIDTH > 1) begin : g_user
      assign tuser_in = {s_img_user, sof};
      logic unused_status;
      assign unused_status = s_img_row_last;
    end else begin : g_no_user
      assign tuser_in = sof;
      logic unused_status;
      assign unused_status = s_img_row_last ^ (^s_img_user);
    end
  endgenerate

  assign wr_entry = {tuser_in, s_img_col_last, s_img_data};

  // Frame sync FSM, overflow detection and push decision.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    ovf_event = beat & fifo_full & ~pop;
    if (ovf_event) begin
      state_d = WAIT_SOF;
    end else begin
      case (state_q)
        WAIT_SOF: begin
          if (sof) begin
            push    = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          push = beat;
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  // Next-cycle occupancy drives the cke request so it reflects this cycle's push/pop.
  always_comb begin
    level_next = level + {{FIFO_PTR_WIDTH{1'b0}}, push} - {{FIFO_PTR_WIDTH{1'b0}}, pop};
    free_next  = DEPTH_W - level_next;
    cke_req_d  = (free_next > MARGIN_W);
    overflow_d = overflow_q;
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // State, cke request and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_SOF;
      cke_req_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cke_req_q  <= cke_req_d;
      overflow_q <= overflow_d;
    end
  end

  jelly2_img_to_axi4s_fifo #(
    .WIDTH     (EW),
    .PTR_WIDTH (FIFO_PTR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (wr_entry),
    .rd_en    (pop),
    .rd_data  (rd_entry),
    .rd_valid (m_axi4s_tvalid),
    .full     (fifo_full),
    .level    (level)
  );

  assign m_axi4s_tuser   = rd_entry[EW-1 -: TUSER_WIDTH];
  assign m_axi4s_tlast   = rd_entry[TDATA_WIDTH];
  assign m_axi4s_tdata   = rd_entry[TDATA_WIDTH-1:0];
  assign m_img_cke_req   = cke_req_q;
  assign status_overflow = overflow_q;
  assign status_level    = level;

endmodule

// File: tb/tb_jelly2_img_to_axi4s_buffered.sv
// Self-checking bench: randomized image-bus frames against a queue-based model.
module tb_jelly2_img_to_axi4s_buffered;

  localparam int TUSER_WIDTH = 3;
  localparam int UW          = 2;
  localparam int TDATA_WIDTH = 8;
  localparam int PTR         = 5;
  localparam int DEPTH       = 32;
  localparam int MARGIN      = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_img_cke, s_img_row_first, s_img_row_last;
  logic             s_img_col_first, s_img_col_last, s_img_de, s_img_valid;
  logic [UW-1:0]    s_img_user;
  logic [7:0]       s_img_data;
  logic             m_img_cke_req;
  logic [2:0]       m_axi4s_tuser;
  logic             m_axi4s_tlast;
  logic [7:0]       m_axi4s_tdata;
  logic             m_axi4s_tvalid;
  logic             m_axi4s_tready;
  logic             clear_overflow;
  logic             status_overflow;
  logic [PTR:0]     status_level;

  jelly2_img_to_axi4s_buffered #(
    .TUSER_WIDTH    (TUSER_WIDTH),
    .TDATA_WIDTH    (TDATA_WIDTH),
    .FIFO_PTR_WIDTH (PTR),
    .CKE_MARGIN     (MARGIN)
  ) dut (
    .reset           (reset),
    .clk             (clk),
    .s_img_cke       (s_img_cke),
    .s_img_row_first (s_img_row_first),
    .s_img_row_last  (s_img_row_last),
    .s_img_col_first (s_img_col_first),
    .s_img_col_last  (s_img_col_last),
    .s_img_de        (s_img_de),
    .s_img_user      (s_img_user),
    .s_img_data      (s_img_data),
    .s_img_valid     (s_img_valid),
    .m_img_cke_req   (m_img_cke_req),
    .m_axi4s_tuser   (m_axi4s_tuser),
    .m_axi4s_tlast   (m_axi4s_tlast),
    .m_axi4s_tdata   (m_axi4s_tdata),
    .m_axi4s_tvalid  (m_axi4s_tvalid),
    .m_axi4s_tready  (m_axi4s_tready),
    .clear_overflow  (clear_overflow),
    .status_overflow (status_overflow),
    .status_level    (status_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    data;
    logic [UW-1:0] user;
    logic          sof;
    logic          last;
  } pix_t;

  pix_t mq[$];
  bit   m_sync;
  bit   m_ovf;
  bit   m_cke;
  int   n_out;
  int   tready_mode;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive_tready();
    logic [31:0] r;
    r = $urandom;
    case (tready_mode)
      0: m_axi4s_tready = 1'b1;
      1: m_axi4s_tready = ~m_axi4s_tready;
      2: m_axi4s_tready = 1'b0;
      default: m_axi4s_tready = r[0];
    endcase
  endtask

  // Compare DUT against the model, advance the model by one clock, then take the edge.
  task automatic step();
    bit beat, sof, pop, full, ovf_ev, push;
    pix_t p;
    chk("tvalid", 32'(m_axi4s_tvalid), 32'(mq.size() != 0));
    chk("level", 32'(status_level), 32'(mq.size()));
    chk("cke_req", 32'(m_img_cke_req), 32'(m_cke));
    chk("overflow", 32'(status_overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      chk("tdata", 32'(m_axi4s_tdata), 32'(mq[0].data));
      chk("tuser", 32'(m_axi4s_tuser), 32'({mq[0].user, mq[0].sof}));
      chk("tlast", 32'(m_axi4s_tlast), 32'(mq[0].last));
    end
    if (reset) begin
      mq.delete();
      m_sync = 1'b0;
      m_ovf  = 1'b0;
      m_cke  = 1'b0;
    end else begin
      beat   = s_img_cke && s_img_valid && s_img_de;
      sof    = beat && s_img_row_first && s_img_col_first;
      pop    = (mq.size() != 0) && m_axi4s_tready;
      full   = (mq.size() == DEPTH);
      ovf_ev = beat && full && !pop;
      push   = beat && (m_sync || sof) && !ovf_ev;
      if (pop) begin
        void'(mq.pop_front());
        n_out++;
      end
      if (push) begin
        p.data = s_img_data;
        p.user = s_img_user;
        p.sof  = sof;
        p.last = s_img_col_last;
        mq.push_back(p);
      end
      if (ovf_ev) m_sync = 1'b0;
      else if (push) m_sync = 1'b1;
      if (ovf_ev) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      m_cke = (DEPTH - mq.size()) > MARGIN;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    s_img_cke = 1'b1; s_img_valid = 1'b0; s_img_de = 1'b0;
    s_img_row_first = 1'b0; s_img_row_last = 1'b0;
    s_img_col_first = 1'b0; s_img_col_last = 1'b0;
    s_img_user = '0; s_img_data = '0;
  endtask

  task automatic idle(input int n);
    bus_idle();
    for (int i = 0; i < n; i++) begin
      drive_tready();
      step();
    end
  endtask

  task automatic set_pix(input int idx, input int rows, input int cols, input bit seq);
    logic [31:0] r;
    int row, col;
    row = idx / cols;
    col = idx % cols;
    r = $urandom;
    s_img_row_first = (row == 0);
    s_img_row_last  = (row == rows - 1);
    s_img_col_first = (col == 0);
    s_img_col_last  = (col == cols - 1);
    s_img_valid     = 1'b1;
    s_img_user      = r[9:8];
    s_img_data      = seq ? 8'(idx) : r[7:0];
  endtask

  // Present pixels [first, last_excl) of a rows x cols frame; each pixel holds until it beats.
  task automatic frame(input int rows, input int cols, input int first, input int last_excl,
                       input bit honor, input bit seq, input int gap_pct);
    int idx;
    int budget;
    bit adv;
    idx = first;
    budget = 3000;
    while (idx < last_excl && budget > 0) begin
      set_pix(idx, rows, cols, seq);
      s_img_de  = ($urandom_range(99) >= gap_pct);
      s_img_cke = honor ? m_img_cke_req : 1'b1;
      drive_tready();
      adv = s_img_cke && s_img_de;
      step();
      if (adv) idx++;
      budget--;
    end
    if (budget == 0) chk("frame_budget", 32'(idx), 32'(last_excl));
    bus_idle();
  endtask

  initial begin
    int base;
    n_chk = 0; n_pass = 0; n_out = 0;
    m_sync = 1'b0; m_ovf = 1'b0; m_cke = 1'b0;
    tready_mode = 0;
    m_axi4s_tready = 1'b1;
    clear_overflow = 1'b0;
    bus_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_tvalid", 32'(m_axi4s_tvalid), 0);
    chk("rst_level", 32'(status_level), 0);
    chk("rst_ovf", 32'(status_overflow), 0);
    chk("rst_cke", 32'(m_img_cke_req), 0);
    idle(2);
    chk("cke_after_rst", 32'(m_img_cke_req), 1);

    // 1: 4x3 frame, data 0..11, tready=1
    tready_mode = 0;
    base = n_out;
    frame(3, 4, 0, 12, 0, 1, 0);
    idle(4);
    chk("t1_count", 32'(n_out - base), 12);

    // 2: same frame, tready toggling
    tready_mode = 1;
    base = n_out;
    frame(3, 4, 0, 12, 0, 1, 0);
    idle(30);
    chk("t2_count", 32'(n_out - base), 12);

    // 3: stalled sink, upstream honours cke_req
    tready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      set_pix(i % 64, 8, 8, 1);
      s_img_de  = 1'b1;
      s_img_cke = m_img_cke_req;
      drive_tready();
      step();
    end
    chk("t3_level", 32'(status_level), DEPTH - MARGIN);
    chk("t3_ovf", 32'(status_overflow), 0);
    chk("t3_cke", 32'(m_img_cke_req), 0);
    tready_mode = 0;
    idle(40);

    // 4: ignore cke_req, 40 beats into a stalled sink
    tready_mode = 2;
    frame(5, 8, 0, 40, 0, 1, 0);
    idle(1);
    chk("t4_ovf", 32'(status_overflow), 1);
    chk("t4_level", 32'(status_level), DEPTH);
    tready_mode = 0;
    base = n_out;
    frame(3, 4, 0, 12, 0, 0, 20);
    idle(45);
    chk("t4_count", 32'(n_out - base), DEPTH + 12);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    idle(1);
    chk("t4_clear", 32'(status_overflow), 0);

    // 5: after reset, a partial frame then a full frame
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    base = n_out;
    frame(3, 4, 5, 12, 0, 0, 0);
    frame(3, 4, 0, 12, 0, 0, 0);
    idle(10);
    chk("t5_count", 32'(n_out - base), 12);

    // 6: reset with 10 entries queued
    tready_mode = 2;
    frame(4, 4, 0, 10, 0, 0, 0);
    idle(1);
    chk("t6_level_pre", 32'(status_level), 10);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t6_tvalid", 32'(m_axi4s_tvalid), 0);
    chk("t6_level", 32'(status_level), 0);
    tready_mode = 0;
    base = n_out;
    frame(4, 4, 10, 16, 0, 0, 0);
    frame(3, 4, 0, 12, 0, 0, 0);
    idle(10);
    chk("t6_count", 32'(n_out - base), 12);

    // Random frames, random backpressure and gaps, upstream honouring cke_req
    tready_mode = 3;
    for (int f = 0; f < 8; f++) begin
      int rows, cols;
      rows = $urandom_range(4, 1);
      cols = $urandom_range(6, 1);
      frame(rows, cols, 0, rows * cols, f[0], 0, 30);
    end
    tready_mode = 0;
    idle(40);
    chk("rand_drained", 32'(status_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
